// File: rtl/lcd_bus_reader.sv
// HD44780 8-bit bus read master: status reads (optionally polled until BF clears) and data reads.
// Optional BF-poll abort after POLL_MAX busy reads is built when LCD_POLL_TIMEOUT_EN is defined.
module lcd_bus_reader #(
    parameter int unsigned SETUP_CYC   = 4,
    parameter int unsigned EN_HIGH_CYC = 50_000,
    parameter int unsigned EN_LOW_CYC  = 50_000,
    parameter int unsigned POLL_MAX    = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       req_rs,
    input  logic       req_wait,
    input  logic [7:0] lcd_din,
    output logic       bus_own,
    output logic       EN,
    output logic       RW,
    output logic       RS,
    output logic       ready,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       bf,
    output logic [6:0] addr,
    output logic       timeout
);

    typedef enum logic [2:0] {IDLE, SETUP, EN_HI, EN_LO, DONE} state_t;

    localparam logic [31:0] SETUP_LD = SETUP_CYC - 1;
    localparam logic [31:0] HI_LD    = EN_HIGH_CYC - 1;
    localparam logic [31:0] LO_LD    = EN_LOW_CYC - 1;

    if (SETUP_CYC == 0 || EN_HIGH_CYC == 0 || EN_LOW_CYC == 0 || POLL_MAX == 0) begin : g_param_check
        $error("lcd_bus_reader: all cycle counts and POLL_MAX must be nonzero");
    end

    state_t      state;
    logic [31:0] cnt;
    logic        want_data;
    logic        polling;
    logic [7:0]  last_byte;
`ifdef LCD_POLL_TIMEOUT_EN
    logic [31:0] poll_cnt;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            want_data <= 1'b0;
            polling   <= 1'b0;
            last_byte <= '0;
            bus_own   <= 1'b0;
            EN        <= 1'b0;
            RW        <= 1'b0;
            RS        <= 1'b0;
            ready     <= 1'b1;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            bf        <= 1'b0;
            addr      <= '0;
            timeout   <= 1'b0;
`ifdef LCD_POLL_TIMEOUT_EN
            poll_cnt  <= '0;
`endif
        end else begin
            rd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    // First IDLE cycle after DONE releases the bus; req is not accepted until ready=1.
                    if (!ready) begin
                        ready   <= 1'b1;
                        bus_own <= 1'b0;
                        RW      <= 1'b0;
                        RS      <= 1'b0;
                    end else if (req) begin
                        want_data <= req_rs;
                        polling   <= req_wait;
                        RS        <= req_wait ? 1'b0 : req_rs;
                        RW        <= 1'b1;
                        bus_own   <= 1'b1;
                        ready     <= 1'b0;
                        timeout   <= 1'b0;
                        cnt       <= SETUP_LD;
                        state     <= SETUP;
`ifdef LCD_POLL_TIMEOUT_EN
                        poll_cnt  <= '0;
`endif
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        EN    <= 1'b1;
                        cnt   <= HI_LD;
                        state <= EN_HI;
                    end else begin
                        cnt <= cnt - 1;
                    end
                end
                EN_HI: begin
                    if (cnt == '0) begin
                        EN        <= 1'b0;
                        cnt       <= LO_LD;
                        state     <= EN_LO;
                        last_byte <= lcd_din;
                        if (!RS) begin
                            bf   <= lcd_din[7];
                            addr <= lcd_din[6:0];
`ifdef LCD_POLL_TIMEOUT_EN
                            if (polling && lcd_din[7])
                                poll_cnt <= poll_cnt + 1;
`endif
                        end
                    end else begin
                        cnt <= cnt - 1;
                    end
                end
                EN_LO: begin
                    if (cnt == '0) begin
                        if (polling && last_byte[7]) begin
`ifdef LCD_POLL_TIMEOUT_EN
                            if (poll_cnt >= POLL_MAX) begin
                                timeout <= 1'b1;
                                state   <= DONE;
                            end else begin
                                RS    <= 1'b0;
                                cnt   <= SETUP_LD;
                                state <= SETUP;
                            end
`else
                            RS    <= 1'b0;
                            cnt   <= SETUP_LD;
                            state <= SETUP;
`endif
                        end else if (polling && want_data) begin
                            polling <= 1'b0;
                            RS      <= 1'b1;
                            cnt     <= SETUP_LD;
                            state   <= SETUP;
                        end else begin
                            state <= DONE;
                        end
                    end else begin
                        cnt <= cnt - 1;
                    end
                end
                DONE: begin
                    rd_valid <= 1'b1;
                    rd_data  <= last_byte;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_bus_reader.sv
// Scoreboard bench for lcd_bus_reader; an LCD responder feeds lcd_din per EN pulse.
// The timeout case runs only when LCD_POLL_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_lcd_bus_reader;

    localparam int unsigned S  = 2;
    localparam int unsigned H  = 4;
    localparam int unsigned L  = 4;
    localparam int unsigned PM = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req = 1'b0;
    logic       req_rs = 1'b0;
    logic       req_wait = 1'b0;
    logic [7:0] lcd_din = '0;
    logic       bus_own, EN, RW, RS, ready, rd_valid, bf, timeout;
    logic [7:0] rd_data;
    logic [6:0] addr;

    lcd_bus_reader #(
        .SETUP_CYC  (S),
        .EN_HIGH_CYC(H),
        .EN_LOW_CYC (L),
        .POLL_MAX   (PM)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .req_rs  (req_rs),
        .req_wait(req_wait),
        .lcd_din (lcd_din),
        .bus_own (bus_own),
        .EN      (EN),
        .RW      (RW),
        .RS      (RS),
        .ready   (ready),
        .rd_valid(rd_valid),
        .rd_data (rd_data),
        .bf      (bf),
        .addr    (addr),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       bf;
        logic [6:0] addr;
        logic       to;
        int         acc;
        int         lat;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] din_q[$];
    logic       rs_log[$];
    int n_cmp = 0, n_bad = 0;
    int cyc = 0, pulses = 0, valids = 0, en_w = 0;
    logic en_q = 1'b0, rs_at_rise = 1'b0, ready_due = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // LCD responder and output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (ready_due) check("ready_after_valid", ready, 1);
        ready_due = rd_valid;
        if (EN && !en_q) begin
            pulses++;
            rs_log.push_back(RS);
            rs_at_rise = RS;
            en_w = 1;
            check("rw_at_en", RW, 1);
            check("own_at_en", bus_own, 1);
            if (din_q.size() > 0) lcd_din = din_q.pop_front();
        end else if (EN) begin
            en_w++;
            if (RS !== rs_at_rise) check("rs_stable", RS, rs_at_rise);
        end else if (en_q && rst) begin
            check("en_width", en_w, H);
        end
        if (rd_valid) begin
            valids++;
            check("ready_at_valid", ready, 0);
            if (exp_q.size() == 0) begin
                check("spurious_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("rd_data", rd_data, e.data);
                check("bf", bf, e.bf);
                check("addr", addr, e.addr);
                check("timeout", timeout, e.to);
                check("latency", cyc - e.acc, e.lat);
            end
        end
        en_q = EN;
    end

    task automatic start_req(input logic rs, input logic w, output int acc);
        for (int n = 0; n < 100 && !ready; n++) @(negedge clk);
        if (!ready) check("ready_wait", 0, 1);
        req = 1'b1; req_rs = rs; req_wait = w;
        acc = cyc + 1;
        @(negedge clk);
        req = 1'b0; req_rs = 1'b0; req_wait = 1'b0;
    endtask

    task automatic push_exp(input logic [7:0] d, input logic b, input logic [6:0] a,
                            input logic t, input int acc, input int lat);
        exp_t e;
        e.data = d; e.bf = b; e.addr = a; e.to = t; e.acc = acc; e.lat = lat;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input int v0, input int budget);
        for (int n = 0; n < budget && valids == v0; n++) @(negedge clk);
        check("done_in_time", (valids != v0) ? 1 : 0, 1);
        @(negedge clk);
    endtask

    initial begin
        int acc, p0, v0;
        logic [3:0] pat;

        repeat (3) @(negedge clk);
        check("rst_EN", EN, 0);
        check("rst_RW", RW, 0);
        check("rst_RS", RS, 0);
        check("rst_own", bus_own, 0);
        check("rst_ready", ready, 1);
        check("rst_valid", rd_valid, 0);
        check("rst_data", rd_data, 0);
        check("rst_bf", bf, 0);
        check("rst_addr", addr, 0);
        check("rst_timeout", timeout, 0);
        rst = 1'b1;
        @(negedge clk);

        // status read
        din_q.push_back(8'h45); rs_log.delete(); p0 = pulses; v0 = valids;
        start_req(1'b0, 1'b0, acc);
        push_exp(8'h45, 1'b0, 7'h45, 1'b0, acc, S + H + L + 1);
        wait_done(v0, 100);
        check("t1_pulses", pulses - p0, 1);
        check("t1_rs", rs_log[0], 0);

        // data read leaves bf/addr alone
        din_q.push_back(8'h2D); rs_log.delete(); p0 = pulses; v0 = valids;
        start_req(1'b1, 1'b0, acc);
        push_exp(8'h2D, 1'b0, 7'h45, 1'b0, acc, S + H + L + 1);
        wait_done(v0, 100);
        check("t2_pulses", pulses - p0, 1);
        check("t2_rs", rs_log[0], 1);

        // poll BF until clear, then data read
        din_q.push_back(8'h80); din_q.push_back(8'h80);
        din_q.push_back(8'h05); din_q.push_back(8'h30);
        rs_log.delete(); p0 = pulses; v0 = valids;
        start_req(1'b1, 1'b1, acc);
        push_exp(8'h30, 1'b0, 7'h05, 1'b0, acc, 4 * (S + H + L) + 1);
        wait_done(v0, 200);
        check("t3_pulses", pulses - p0, 4);
        pat = {rs_log[0], rs_log[1], rs_log[2], rs_log[3]};
        check("t3_rs_seq", pat, 4'b0001);

`ifdef LCD_POLL_TIMEOUT_EN
        // BF stuck high: abort after POLL_MAX status reads
        din_q.push_back(8'h80); rs_log.delete(); p0 = pulses; v0 = valids;
        start_req(1'b1, 1'b1, acc);
        push_exp(8'h80, 1'b1, 7'h00, 1'b1, acc, PM * (S + H + L) + 1);
        wait_done(v0, 200);
        check("t4_pulses", pulses - p0, PM);
        pat = '0;
        foreach (rs_log[i]) pat[0] = pat[0] | rs_log[i];
        check("t4_no_data_rs", pat, 0);
`endif

        // reset during second EN_HI cycle
        din_q.delete(); din_q.push_back(8'h45); v0 = valids;
        start_req(1'b0, 1'b0, acc);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t5_EN", EN, 0);
        check("t5_RW", RW, 0);
        check("t5_own", bus_own, 0);
        check("t5_ready", ready, 1);
        check("t5_valid", rd_valid, 0);
        check("t5_data", rd_data, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("t5_no_valid", valids - v0, 0);
        din_q.delete(); din_q.push_back(8'h45); v0 = valids;
        start_req(1'b0, 1'b0, acc);
        push_exp(8'h45, 1'b0, 7'h45, 1'b0, acc, S + H + L + 1);
        wait_done(v0, 100);

        // req while busy is ignored
        din_q.delete(); din_q.push_back(8'h5A); rs_log.delete(); p0 = pulses; v0 = valids;
        start_req(1'b1, 1'b0, acc);
        push_exp(8'h5A, 1'b0, 7'h45, 1'b0, acc, S + H + L + 1);
        repeat (4) @(negedge clk);
        req = 1'b1; req_rs = 1'b0; req_wait = 1'b1;
        @(negedge clk);
        req = 1'b0; req_rs = 1'b0; req_wait = 1'b0;
        wait_done(v0, 100);
        repeat (30) @(negedge clk);
        check("t6_valids", valids - v0, 1);
        check("t6_pulses", pulses - p0, 1);
        check("t6_rs", rs_log[0], 1);
        check("exp_q_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
